// File: rtl/fwd_hazard_chain_if.sv
// Bundle between the ID stage, the datapath and the hazard/forwarding chain.
// Handshake: the ID entry on in_* is consumed at a rising clk edge only when
// advance=1 and in_ready=1 in the same cycle; while in_ready=0 the ID stage
// must hold its entry, and stage 0 keeps its contents.
interface fwd_hazard_chain_if #(
  parameter int DEPTH = 3,
  parameter int XLEN  = 32,
  parameter int NSRC  = 2,
  parameter int REGW  = 5,
  parameter int CNTW  = 32
);
  localparam int LATW = $clog2(DEPTH);

  logic                   advance;
  logic                   flush;
  logic                   in_valid;
  logic                   in_we;
  logic [REGW-1:0]        in_rd;
  logic [LATW-1:0]        in_lat;
  logic [NSRC*REGW-1:0]   in_rs;
  logic [NSRC-1:0]        in_rs_used;
  logic [DEPTH*XLEN-1:0]  stage_data;

  logic                   in_ready;
  logic                   stall_req;
  logic [NSRC-1:0]        fwd_hit;
  logic [NSRC*LATW-1:0]   fwd_stage;
  logic [NSRC*XLEN-1:0]   fwd_data;
  logic                   ret_valid;
  logic                   ret_we;
  logic [REGW-1:0]        ret_rd;
  logic [CNTW-1:0]        stall_cnt;
  logic [CNTW-1:0]        flush_cnt;

  modport master (
    output advance, flush, in_valid, in_we, in_rd, in_lat, in_rs, in_rs_used, stage_data,
    input  in_ready, stall_req, fwd_hit, fwd_stage, fwd_data,
           ret_valid, ret_we, ret_rd, stall_cnt, flush_cnt
  );

  modport slave (
    input  advance, flush, in_valid, in_we, in_rd, in_lat, in_rs, in_rs_used, stage_data,
    output in_ready, stall_req, fwd_hit, fwd_stage, fwd_data,
           ret_valid, ret_we, ret_rd, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fwd_hazard_chain.sv
// Pipeline metadata chain: tracks rd/we/latency and consumer sources for
// DEPTH stages after ID (stage 0 = EX consumer, DEPTH-1 = WB), picks the
// youngest forwarding producer per source, detects load-use hazards and
// inserts bubbles. Saturating stall/flush counters.
module fwd_hazard_chain #(
  parameter int DEPTH = 3,
  parameter int XLEN  = 32,
  parameter int NSRC  = 2,
  parameter int REGW  = 5,
  parameter int CNTW  = 32
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_chain_if.slave bus
);
  localparam int LATW = $clog2(DEPTH);

  // Per-stage entry fields
  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0]       r_we;
  logic [REGW-1:0]        r_rd      [DEPTH];
  logic [LATW-1:0]        r_lat     [DEPTH];
  logic [NSRC*REGW-1:0]   r_rs      [DEPTH];
  logic [NSRC-1:0]        r_rs_used [DEPTH];
  logic [CNTW-1:0]        r_stall_cnt;
  logic [CNTW-1:0]        r_flush_cnt;

  logic [NSRC-1:0]        w_hit;
  logic [NSRC-1:0]        w_stall_src;
  logic [NSRC*LATW-1:0]   w_fwd_stage;
  logic [NSRC*XLEN-1:0]   w_fwd_data;
  logic                   w_stall;

  // Producer search: scan oldest to youngest so the smallest matching k wins
  always_comb begin : p_fwd
    logic            l_found;
    logic            l_rdy;
    logic [LATW-1:0] l_k;
    logic [XLEN-1:0] l_data;
    logic [REGW-1:0] l_rs;
    w_hit       = '0;
    w_stall_src = '0;
    w_fwd_stage = '0;
    w_fwd_data  = '0;
    l_found     = 1'b0;
    l_rdy       = 1'b0;
    l_k         = '0;
    l_data      = '0;
    l_rs        = '0;
    for (int i = 0; i < NSRC; i++) begin
      l_found = 1'b0;
      l_rdy   = 1'b0;
      l_k     = '0;
      l_data  = '0;
      l_rs    = r_rs[0][i*REGW +: REGW];
      for (int k = DEPTH-1; k >= 1; k--) begin
        if (r_valid[0] && r_rs_used[0][i] && (l_rs != '0) &&
            r_valid[k] && r_we[k] && (r_rd[k] == l_rs)) begin
          l_found = 1'b1;
          l_rdy   = (k >= int'(r_lat[k]));
          l_k     = LATW'(k);
          l_data  = bus.stage_data[k*XLEN +: XLEN];
        end
      end
      if (l_found && l_rdy) begin
        w_hit[i]                     = 1'b1;
        w_fwd_stage[i*LATW +: LATW]  = l_k;
        w_fwd_data[i*XLEN +: XLEN]   = l_data;
      end else if (l_found) begin
        w_stall_src[i] = 1'b1;
      end
    end
  end

  assign w_stall = |w_stall_src;

  // Chain advance: stall holds stage 0 and drops a bubble into stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k]   <= 1'b0;
        r_we[k]      <= 1'b0;
        r_rd[k]      <= '0;
        r_lat[k]     <= '0;
        r_rs[k]      <= '0;
        r_rs_used[k] <= '0;
      end
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.advance) begin
      for (int k = 2; k < DEPTH; k++) begin
        r_valid[k]   <= r_valid[k-1];
        r_we[k]      <= r_we[k-1];
        r_rd[k]      <= r_rd[k-1];
        r_lat[k]     <= r_lat[k-1];
        r_rs[k]      <= r_rs[k-1];
        r_rs_used[k] <= r_rs_used[k-1];
      end
      if (w_stall) begin
        r_valid[1]   <= 1'b0;
        r_we[1]      <= 1'b0;
        r_rd[1]      <= '0;
        r_lat[1]     <= '0;
        r_rs[1]      <= '0;
        r_rs_used[1] <= '0;
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end else begin
        r_valid[1]   <= r_valid[0];
        r_we[1]      <= r_we[0];
        r_rd[1]      <= r_rd[0];
        r_lat[1]     <= r_lat[0];
        r_rs[1]      <= r_rs[0];
        r_rs_used[1] <= r_rs_used[0];
        if (bus.in_valid && !bus.flush) begin
          r_valid[0]   <= 1'b1;
          r_we[0]      <= bus.in_we;
          r_rd[0]      <= bus.in_rd;
          r_lat[0]     <= bus.in_lat;
          r_rs[0]      <= bus.in_rs;
          r_rs_used[0] <= bus.in_rs_used;
        end else begin
          r_valid[0]   <= 1'b0;
          r_we[0]      <= 1'b0;
          r_rd[0]      <= '0;
          r_lat[0]     <= '0;
          r_rs[0]      <= '0;
          r_rs_used[0] <= '0;
        end
        if (bus.flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNTW'(1);
      end
    end
  end

  // A branch cannot resolve while the consumer is stalled; stall wins if it does.
  a_no_flush_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.advance && bus.flush && w_stall));

  assign bus.in_ready  = ~w_stall;
  assign bus.stall_req = w_stall;
  assign bus.fwd_hit   = w_hit;
  assign bus.fwd_stage = w_fwd_stage;
  assign bus.fwd_data  = w_fwd_data;
  assign bus.ret_valid = r_valid[DEPTH-1];
  assign bus.ret_we    = r_valid[DEPTH-1] & r_we[DEPTH-1];
  assign bus.ret_rd    = r_valid[DEPTH-1] ? r_rd[DEPTH-1] : '0;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_fwd_hazard_chain.sv
// Directed bench for fwd_hazard_chain: driver pushes hand-computed expected
// output snapshots into a queue; a monitor pops and compares at negedge.
module tb_fwd_hazard_chain;
  localparam int DEPTH = 3;
  localparam int XLEN  = 32;
  localparam int NSRC  = 2;
  localparam int REGW  = 5;
  localparam int CNTW  = 32;
  localparam int EW    = 143;
  localparam logic [31:0] D0 = 32'hAAAA0000;
  localparam logic [31:0] D1 = 32'hBBBB0001;
  localparam logic [31:0] D2 = 32'hCCCC0002;

  logic clk = 1'b0;
  logic rst_n;
  logic sample_tgl = 1'b0;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks   = 0;
  int            failures = 0;

  fwd_hazard_chain_if #(.DEPTH(DEPTH), .XLEN(XLEN), .NSRC(NSRC), .REGW(REGW), .CNTW(CNTW)) ifc ();

  fwd_hazard_chain #(.DEPTH(DEPTH), .XLEN(XLEN), .NSRC(NSRC), .REGW(REGW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected snapshot: {in_ready, stall_req, fwd_hit, st1, st0, d1, d0, ret_valid, ret_we, ret_rd, stall_cnt, flush_cnt}
  function automatic logic [EW-1:0] ev(input logic rdy, input logic stall, input logic [1:0] hit,
                                       input logic [1:0] st0, input logic [1:0] st1,
                                       input logic [31:0] d0, input logic [31:0] d1,
                                       input logic rv, input logic rwe, input logic [4:0] rrd,
                                       input logic [31:0] sc, input logic [31:0] fc);
    return {rdy, stall, hit, st1, st0, d1, d0, rv, rwe, rrd, sc, fc};
  endfunction

  function automatic logic [EW-1:0] rst_vec();
    return ev(1'b1, 1'b0, 2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endfunction

  // driver tasks
  task automatic drive(input logic adv, input logic fl, input logic v, input logic we,
                       input logic [4:0] rd, input logic [1:0] lat,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used);
    ifc.advance    = adv;
    ifc.flush      = fl;
    ifc.in_valid   = v;
    ifc.in_we      = we;
    ifc.in_rd      = rd;
    ifc.in_lat     = lat;
    ifc.in_rs      = {rs2, rs1};
    ifc.in_rs_used = used;
  endtask

  task automatic push_exp(input string name, input logic [EW-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // one clock edge, then queue the expectation for the updated chain
  task automatic tick(input string name, input logic [EW-1:0] e);
    @(posedge clk);
    #1;
    push_exp(name, e);
  endtask

  // scoreboard monitor
  always @(negedge clk or sample_tgl) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    string         n;
    act = {ifc.in_ready, ifc.stall_req, ifc.fwd_hit, ifc.fwd_stage, ifc.fwd_data,
           ifc.ret_valid, ifc.ret_we, ifc.ret_rd, ifc.stall_cnt, ifc.flush_cnt};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    ifc.stage_data = {D2, D1, D0};
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
    #1;
    push_exp("reset", rst_vec());
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // ALU producer then dependent consumer
    drive(1, 0, 1, 1, 5'd5, 2'd1, 5'd0, 5'd0, 2'b00);
    tick("issue_i1", ev(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0));
    drive(1, 0, 1, 1, 5'd8, 2'd1, 5'd5, 5'd3, 2'b11);
    tick("alu_dep", ev(1, 0, 2'b01, 2'd1, 0, D1, 0, 0, 0, 5'd0, 0, 0));

    // load then dependent consumer -> stall, then forward from stage 2
    drive(1, 0, 1, 1, 5'd6, 2'd2, 5'd0, 5'd0, 2'b00);
    tick("ret_i1", ev(1, 0, 2'b00, 0, 0, 0, 0, 1, 1, 5'd5, 0, 0));
    drive(1, 0, 1, 0, 5'd0, 2'd1, 5'd6, 5'd0, 2'b01);
    tick("load_use", ev(0, 1, 2'b00, 0, 0, 0, 0, 1, 1, 5'd8, 0, 0));
    drive(1, 0, 1, 1, 5'd9, 2'd1, 5'd0, 5'd0, 2'b00);
    tick("load_use_fwd", ev(1, 0, 2'b01, 2'd2, 0, D2, 0, 1, 1, 5'd6, 1, 0));

    // two producers of r7, youngest must win
    drive(1, 0, 1, 1, 5'd7, 2'd1, 5'd0, 5'd0, 2'b00);
    tick("issue_p1", ev(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 1, 0));
    drive(1, 0, 1, 1, 5'd7, 2'd1, 5'd0, 5'd0, 2'b00);
    tick("issue_p2", ev(1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 5'd0, 1, 0));
    drive(1, 0, 1, 0, 5'd3, 2'd1, 5'd0, 5'd7, 2'b10);
    tick("youngest", ev(1, 0, 2'b10, 0, 2'd1, 0, D1, 1, 1, 5'd7, 1, 0));

    // x0 producer and x0 consumer never match
    drive(1, 0, 1, 1, 5'd0, 2'd1, 5'd0, 5'd0, 2'b00);
    tick("issue_z", ev(1, 0, 2'b00, 0, 0, 0, 0, 1, 1, 5'd7, 1, 0));
    drive(1, 0, 1, 0, 5'd0, 2'd1, 5'd0, 5'd0, 2'b11);
    tick("x0", ev(1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 5'd3, 1, 0));

    // flush with advance low is ignored, then accepted
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 1, 5'd9, 2'd1, 5'd9, 5'd9, 2'b11);
      tick("flush_hold", ev(1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 5'd3, 1, 0));
    end
    drive(1, 1, 1, 1, 5'd9, 2'd1, 5'd0, 5'd0, 2'b00);
    tick("flush_accept", ev(1, 0, 2'b00, 0, 0, 0, 0, 1, 1, 5'd0, 1, 1));

    // load-use on source 1, hold with advance low, then async reset mid-stall
    drive(1, 0, 1, 1, 5'd10, 2'd2, 5'd0, 5'd0, 2'b00);
    tick("issue_l2", ev(1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 5'd0, 1, 1));
    drive(1, 0, 1, 0, 5'd0, 2'd1, 5'd0, 5'd10, 2'b10);
    tick("load_use_src1", ev(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 1, 1));
    drive(0, 0, 0, 0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
    tick("stall_hold", ev(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 1, 1));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push_exp("reset_mid", rst_vec());
    sample_tgl = ~sample_tgl;
    #1;
    rst_n = 1'b1;
    tick("post_reset", rst_vec());

    // chain works again after reset
    drive(1, 0, 1, 1, 5'd4, 2'd1, 5'd0, 5'd0, 2'b00);
    tick("reissue", rst_vec());
    drive(1, 0, 1, 0, 5'd0, 2'd1, 5'd4, 5'd0, 2'b01);
    tick("alu_dep_post_reset", ev(1, 0, 2'b01, 2'd1, 0, D1, 0, 0, 0, 5'd0, 0, 0));

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
